riscv_imem_loader: RTL and testbench
====================================

Name: riscv_imem_loader

Overview:
- Boot-time program loader for the RV32I cores (single-cycle and pipelined).
- Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially into the instruction memory write port starting at address 0.
- Holds the core in reset while loading, then releases it after a programmable settle delay.
- Replaces file-based IMEM initialisation on FPGA/bring-up builds.

Parameters:
XLEN, 32, data/address width of the imem write port
IMEM_ADDR_BIT, 10, byte-address bits of the instruction memory; capacity is 2**(IMEM_ADDR_BIT-2) words
RELEASE_CYCLES, 4, clock cycles between the last imem write and core reset release; legal range 1..255

Ports:
i_clk  input  1  clock; all state changes on its rising edge
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  starts a load; ignored unless in IDLE
i_word_count  input  IMEM_ADDR_BIT-1  number of words to load; sampled when i_start is accepted
i_byte_valid  input  1  byte stream valid
i_byte_data  input  8  byte stream data
o_byte_ready  output  1  loader accepts a byte this cycle
o_imem_wr_en  output  1  imem write strobe, one cycle per word
o_imem_addr  output  XLEN  imem byte address, word aligned
o_imem_wr_data  output  XLEN  assembled instruction word
o_core_rstn  output  1  active-low reset to the core's i_rstn
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse when the core is released
o_err  output  1  sticky; set when i_word_count exceeds capacity
o_checksum  output  XLEN  modulo-2^XLEN sum of all words written in the current load

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE; o_core_rstn=0; all other outputs 0; internal word buffer, byte index, word counter and release counter cleared. Reset overrides everything, including a load in progress. The core stays in reset after i_rst until a load completes.
- States: IDLE, RECV, WRITE, RELEASE.
- IDLE:
  - o_byte_ready=0.
  - On i_start=1:
    - Latch i_word_count into cnt; clear o_imem_addr, o_checksum, byte index and word counter; drive o_core_rstn=0 from the next cycle.
    - cnt > 2**(IMEM_ADDR_BIT-2): set o_err=1, stay in IDLE, o_core_rstn unchanged.
    - cnt=0: go to RELEASE.
    - Otherwise: clear o_err and go to RECV.
  - o_core_rstn holds its last value while idle.
- RECV:
  - o_byte_ready=1, driven from a register (no combinational path from i_byte_valid).
  - A byte transfers on the cycle where i_byte_valid and o_byte_ready are both 1.
  - Byte k (k=0..3) of a word lands in bits [8k+7:8k].
  - The 4th accepted byte moves the state to WRITE on the next cycle, with the buffer complete.
- WRITE (exactly 1 cycle):
  - o_byte_ready=0; o_imem_wr_en=1; o_imem_wr_data=buffer; o_imem_addr=current address.
  - At the end of the cycle: address += 4, checksum += word, word counter += 1.
  - If the counter reaches cnt, go to RELEASE; otherwise go to RECV.
  - Latency: the write strobe is asserted in the cycle immediately after the 4th byte handshake.
- RELEASE:
  - Count RELEASE_CYCLES cycles with o_core_rstn=0.
  - On the final cycle, drive o_core_rstn=1 and o_done=1 (one cycle), then go to IDLE.
- Addresses wrap modulo 2**IMEM_ADDR_BIT; unreachable when o_err logic is correct.
- o_checksum holds its final value in IDLE until the next accepted i_start.
- Bytes presented while o_byte_ready=0 are not consumed. The source must hold them, per the valid/ready rule: valid, once asserted, stays high with stable data until accepted.
- i_start asserted while o_busy=1 has no effect.
- i_rst mid-load: the partial word is discarded and no imem write occurs from that cycle on. Previously written imem words are not scrubbed.

Test Plan:
1. Reset then idle 10 cycles -> o_core_rstn=0, o_busy=0, o_imem_wr_en never 1, o_done never 1.
2. i_start with i_word_count=2; stream 13 05 10 00 93 05 20 00 with valid held high -> writes 0x00100513 @0x0 and 0x00200593 @0x4. Each write comes 1 cycle after its 4th byte handshake. o_checksum=0x00300AA6. o_core_rstn rises with o_done exactly 4 cycles after the last write.
3. Same stream with i_byte_valid toggling 1/0 every cycle and random stalls -> identical imem writes and checksum; no byte duplicated or dropped.
4. i_word_count=0 -> no writes; o_done after RELEASE_CYCLES; o_checksum=0. i_word_count=257 with IMEM_ADDR_BIT=10 -> o_err=1, state stays IDLE, no writes.
5. i_rst asserted after 2 bytes of word 1 (word 0 already written) -> next cycle all outputs at reset values, o_core_rstn=0. A fresh load then starts again at address 0x0.
6. Second i_start while busy (during RECV) -> ignored. After o_done, a new i_start drops o_core_rstn to 0 on the next cycle and reloads from 0x0.

Source files
------------

// File: rtl/riscv_imem_loader.sv
// Boot loader: assembles little-endian bytes into 32-bit words and writes them to IMEM from address 0.
// Latency: IMEM write 1 cycle after the 4th byte handshake; core released RELEASE_CYCLES after the last write.
// Backpressure: o_byte_ready is registered and high only in RECV; bytes offered at other times wait at the source.
module riscv_imem_loader #(
   parameter int XLEN           = 32,
   parameter int IMEM_ADDR_BIT  = 10,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [IMEM_ADDR_BIT-2:0] i_word_count,
   input  logic                     i_byte_valid,
   input  logic [7:0]               i_byte_data,
   output logic                     o_byte_ready,
   output logic                     o_imem_wr_en,
   output logic [XLEN-1:0]          o_imem_addr,
   output logic [XLEN-1:0]          o_imem_wr_data,
   output logic                     o_core_rstn,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err,
   output logic [XLEN-1:0]          o_checksum
);

   localparam int CW  = IMEM_ADDR_BIT - 1;
   localparam int CAP = 2 ** (IMEM_ADDR_BIT - 2);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, RELEASE} state_t;

   state_t                   state, state_next;
   logic [CW-1:0]            cnt;
   logic [CW-1:0]            words;
   logic [1:0]               byte_idx;
   logic [XLEN-1:0]          buffer;
   logic [IMEM_ADDR_BIT-1:0] addr;
   logic [XLEN-1:0]          checksum;
   logic [7:0]               rel_cnt;
   logic                     core_rstn_q;
   logic                     err;
   logic                     ready;
   logic                     wr_en;
   logic                     done;
   logic                     accept;
   logic                     last_rel;
   logic                     too_big;

   assign accept   = i_byte_valid && ready;
   assign last_rel = (rel_cnt == 8'(RELEASE_CYCLES - 1));
   assign too_big  = (i_word_count > CW'(CAP));

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode plus the strobes that are pure functions of state
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (i_start && !too_big) begin
               if (i_word_count == '0) state_next = RELEASE;
               else                    state_next = RECV;
            end
         end
         RECV: begin
            if (accept && byte_idx == 2'd3) state_next = WRITE;
         end
         WRITE: begin
            wr_en = 1'b1;
            if (CW'(words + CW'(1)) == cnt) state_next = RELEASE;
            else                            state_next = RECV;
         end
         RELEASE: begin
            if (last_rel) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: byte assembly, address/checksum/word counters, release timer, sticky flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt         <= '0;
         words       <= '0;
         byte_idx    <= '0;
         buffer      <= '0;
         addr        <= '0;
         checksum    <= '0;
         rel_cnt     <= '0;
         core_rstn_q <= 1'b0;
         err         <= 1'b0;
         ready       <= 1'b0;
      end else begin
         // Ready follows the upcoming state so it is a flop, never a path from i_byte_valid
         ready <= (state_next == RECV);
         case (state)
            IDLE: begin
               if (i_start) begin
                  cnt      <= i_word_count;
                  words    <= '0;
                  byte_idx <= '0;
                  buffer   <= '0;
                  addr     <= '0;
                  checksum <= '0;
                  rel_cnt  <= '0;
                  if (too_big) begin
                     err <= 1'b1;
                  end else begin
                     core_rstn_q <= 1'b0;
                     if (i_word_count != '0) err <= 1'b0;
                  end
               end
            end
            RECV: begin
               if (accept) begin
                  buffer[{byte_idx, 3'b000} +: 8] <= i_byte_data;
                  byte_idx                        <= byte_idx + 2'd1;
               end
            end
            WRITE: begin
               addr     <= addr + IMEM_ADDR_BIT'(4);
               checksum <= checksum + buffer;
               words    <= words + CW'(1);
               rel_cnt  <= '0;
            end
            RELEASE: begin
               rel_cnt <= rel_cnt + 8'd1;
               // Keep the core running once released, until the next accepted start
               if (last_rel) core_rstn_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_byte_ready   = ready;
   assign o_imem_wr_en   = wr_en;
   assign o_imem_addr    = {{(XLEN - IMEM_ADDR_BIT){1'b0}}, addr};
   assign o_imem_wr_data = buffer;
   assign o_core_rstn    = core_rstn_q | done;
   assign o_busy         = (state != IDLE);
   assign o_done         = done;
   assign o_err          = err;
   assign o_checksum     = checksum;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Bench for riscv_imem_loader: random byte streams against a word-level model of the loader.
// Latency: write/done timing checked against the handshake cycle of each word's last byte.
// Backpressure: source holds valid and data until accepted, with random and toggling gaps.
module tb_riscv_imem_loader;
   localparam int XLEN = 32;
   localparam int IAB  = 10;
   localparam int RC   = 4;

   logic           clk = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_start = 1'b0;
   logic [IAB-2:0] i_word_count = '0;
   logic           i_byte_valid = 1'b0;
   logic [7:0]     i_byte_data = '0;
   logic           o_byte_ready, o_imem_wr_en, o_core_rstn, o_busy, o_done, o_err;
   logic [XLEN-1:0] o_imem_addr, o_imem_wr_data, o_checksum;

   int checks = 0;
   int failures = 0;

   riscv_imem_loader #(.XLEN(XLEN), .IMEM_ADDR_BIT(IAB), .RELEASE_CYCLES(RC)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_word_count(i_word_count),
      .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .o_byte_ready(o_byte_ready),
      .o_imem_wr_en(o_imem_wr_en), .o_imem_addr(o_imem_addr), .o_imem_wr_data(o_imem_wr_data),
      .o_core_rstn(o_core_rstn), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_checksum(o_checksum)
   );

   always #5 clk = ~clk;

   // Observation logs, filled on the falling edge
   typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
   wr_t        wr_q[$];
   int         hs_cyc[$];
   logic [7:0] hs_dat[$];
   int         done_cyc[$];
   int         rise_cyc[$];
   int         ncyc = 0;
   int         last_start = -1;
   logic       prev_rstn = 1'b0;

   always @(negedge clk) begin
      ncyc = ncyc + 1;
      if (o_imem_wr_en === 1'b1) wr_q.push_back('{o_imem_addr, o_imem_wr_data, ncyc});
      if (i_byte_valid && o_byte_ready === 1'b1 && !i_rst) begin
         hs_cyc.push_back(ncyc);
         hs_dat.push_back(i_byte_data);
      end
      if (o_done === 1'b1) done_cyc.push_back(ncyc);
      if (o_core_rstn === 1'b1 && prev_rstn === 1'b0) rise_cyc.push_back(ncyc);
      prev_rstn = o_core_rstn;
      if (i_start && o_busy === 1'b0 && !i_rst) last_start = ncyc;
   end

   // Model: little-endian word w of a byte stream, and the running sum of the first n words
   function automatic logic [31:0] exp_word(input logic [7:0] b[$], input int w);
      return {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
   endfunction

   function automatic logic [31:0] exp_sum(input logic [7:0] b[$], input int n);
      logic [31:0] s = '0;
      for (int w = 0; w < n; w++) s = s + exp_word(b, w);
      return s;
   endfunction

   task automatic clear_logs();
      wr_q.delete(); hs_cyc.delete(); hs_dat.delete(); done_cyc.delete(); rise_cyc.delete();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
   endtask

   task automatic do_start(input logic [IAB-2:0] c);
      i_start = 1'b1; i_word_count = c;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   // mode 0: valid always, 1: toggle 1/0, 2: random gaps. Valid/data held until accepted.
   task automatic stream(input logic [7:0] b[$], input int mode, output bit ok);
      int i = 0;
      int guard = 0;
      bit prev = 1'b0;
      bit hs;
      ok = 1'b1;
      while (i < b.size()) begin
         if (!i_byte_valid) begin
            case (mode)
               0:       i_byte_valid = 1'b1;
               1:       i_byte_valid = !prev;
               default: i_byte_valid = ($urandom_range(0, 2) != 0);
            endcase
            i_byte_data = i_byte_valid ? b[i] : 8'($urandom);
         end
         prev = i_byte_valid;
         @(negedge clk); hs = i_byte_valid && (o_byte_ready === 1'b1);
         @(posedge clk); #1;
         if (hs) begin i++; i_byte_valid = 1'b0; end
         guard++;
         if (guard > 20 * b.size() + 100) begin ok = 1'b0; break; end
      end
      i_byte_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (o_done === 1'b1) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic rand_bytes(input int n, output logic [7:0] b[$]);
      b.delete();
      for (int k = 0; k < n; k++) b.push_back(8'($urandom));
   endtask

   task automatic test_reset();
      bit bad = 1'b0;
      i_rst = 1'b1; idle(2); i_rst = 1'b0;
      clear_logs();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (o_core_rstn !== 1'b0 || o_busy !== 1'b0 || o_byte_ready !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (bad) begin failures++; $display("FAIL reset_idle: rstn/busy/ready not held low"); end
      checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL reset_wr: got %0d writes want 0", wr_q.size()); end
      checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL reset_done: got %0d pulses want 0", done_cyc.size()); end
      checks++; if ({o_err, o_checksum, o_imem_addr} !== '0) begin failures++; $display("FAIL reset_regs: err=%b sum=%h addr=%h want 0", o_err, o_checksum, o_imem_addr); end
   endtask

   task automatic test_basic();
      logic [7:0] b[$] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      bit ok1, ok2;
      clear_logs();
      do_start(2); stream(b, 0, ok1); wait_done(50, ok2);
      checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL basic_timeout: stream=%b done=%b want 1 1", ok1, ok2); end
      checks++;
      if (wr_q.size() != 2 || hs_cyc.size() != 8) begin
         failures++; $display("FAIL basic_count: got %0d writes %0d bytes want 2 8", wr_q.size(), hs_cyc.size());
      end else begin
         for (int w = 0; w < 2; w++) begin
            checks++; if (wr_q[w].addr !== 32'(4*w) || wr_q[w].data !== exp_word(b, w)) begin
               failures++; $display("FAIL basic_wr%0d: got %h@%h want %h@%h", w, wr_q[w].data, wr_q[w].addr, exp_word(b, w), 32'(4*w)); end
            checks++; if (wr_q[w].cyc != hs_cyc[4*w+3] + 1) begin
               failures++; $display("FAIL basic_lat%0d: write at %0d want %0d", w, wr_q[w].cyc, hs_cyc[4*w+3] + 1); end
         end
         checks++; if (done_cyc.size() != 1 || done_cyc[0] != wr_q[1].cyc + RC) begin
            failures++; $display("FAIL basic_done: got %0d pulses first at %0d want 1 at %0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, wr_q[1].cyc + RC); end
         checks++; if (rise_cyc.size() != 1 || rise_cyc[0] != wr_q[1].cyc + RC) begin
            failures++; $display("FAIL basic_rstn_rise: got %0d rises first at %0d want 1 at %0d", rise_cyc.size(), (rise_cyc.size() > 0) ? rise_cyc[0] : -1, wr_q[1].cyc + RC); end
      end
      checks++; if (o_checksum !== 32'h00300AA6 || o_checksum !== exp_sum(b, 2)) begin
         failures++; $display("FAIL basic_sum: got %h want %h", o_checksum, exp_sum(b, 2)); end
      checks++; if (o_core_rstn !== 1'b1 || o_busy !== 1'b0) begin
         failures++; $display("FAIL basic_idle: rstn=%b busy=%b want 1 0", o_core_rstn, o_busy); end
   endtask

   // Same stream under toggling valid, random stalls, then random programs
   task automatic test_stall();
      logic [7:0] b[$];
      bit ok1, ok2;
      int n;
      for (int it = 0; it < 5; it++) begin
         if (it == 0 || it == 1) begin
            b = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00}; n = 2;
         end else begin
            n = $urandom_range(1, 6); rand_bytes(4 * n, b);
         end
         clear_logs();
         do_start(IAB'(n)); stream(b, (it == 0) ? 1 : 2, ok1); wait_done(400, ok2);
         checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL stall%0d_timeout: stream=%b done=%b", it, ok1, ok2); end
         checks++; if (hs_dat.size() != 4 * n || hs_dat != b) begin
            failures++; $display("FAIL stall%0d_bytes: got %0d bytes want %0d in order", it, hs_dat.size(), 4 * n); end
         checks++;
         if (wr_q.size() != n) begin
            failures++; $display("FAIL stall%0d_count: got %0d writes want %0d", it, wr_q.size(), n);
         end else begin
            for (int w = 0; w < n; w++) begin
               if (wr_q[w].addr !== 32'(4*w) || wr_q[w].data !== exp_word(b, w) || wr_q[w].cyc != hs_cyc[4*w+3] + 1) begin
                  failures++; $display("FAIL stall%0d_wr%0d: got %h@%h t%0d want %h@%h t%0d", it, w, wr_q[w].data, wr_q[w].addr, wr_q[w].cyc, exp_word(b, w), 32'(4*w), hs_cyc[4*w+3] + 1);
                  break;
               end
            end
         end
         checks++; if (o_checksum !== exp_sum(b, n)) begin failures++; $display("FAIL stall%0d_sum: got %h want %h", it, o_checksum, exp_sum(b, n)); end
      end
   endtask

   task automatic test_zero_and_err();
      logic [7:0] b[$];
      bit ok1, ok2;
      clear_logs();
      do_start(0); wait_done(20, ok1);
      checks++; if (!ok1 || done_cyc.size() != 1 || done_cyc[0] != last_start + RC) begin
         failures++; $display("FAIL zero_done: got %0d pulses want 1 at %0d", done_cyc.size(), last_start + RC); end
      checks++; if (wr_q.size() != 0 || o_checksum !== '0) begin
         failures++; $display("FAIL zero_wr: got %0d writes sum %h want 0 0", wr_q.size(), o_checksum); end
      clear_logs();
      do_start(257); idle(8);
      checks++; if (o_err !== 1'b1 || o_busy !== 1'b0 || o_core_rstn !== 1'b1) begin
         failures++; $display("FAIL err_flag: err=%b busy=%b rstn=%b want 1 0 1", o_err, o_busy, o_core_rstn); end
      checks++; if (wr_q.size() != 0 || done_cyc.size() != 0) begin
         failures++; $display("FAIL err_wr: got %0d writes %0d dones want 0 0", wr_q.size(), done_cyc.size()); end
      // Exactly full capacity is legal and clears the sticky error
      rand_bytes(1024, b); clear_logs();
      do_start(256); stream(b, 0, ok1); wait_done(50, ok2);
      checks++; if (!(ok1 && ok2) || o_err !== 1'b0) begin
         failures++; $display("FAIL cap_run: stream=%b done=%b err=%b want 1 1 0", ok1, ok2, o_err); end
      checks++; if (wr_q.size() != 256 || wr_q[wr_q.size()-1].addr !== 32'h3FC || o_checksum !== exp_sum(b, 256)) begin
         failures++; $display("FAIL cap_wr: got %0d writes sum %h want 256 %h", wr_q.size(), o_checksum, exp_sum(b, 256)); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b[$];
      logic [7:0] p[$];
      bit ok1, ok2;
      rand_bytes(8, b);
      for (int k = 0; k < 6; k++) p.push_back(b[k]);
      clear_logs();
      do_start(2); stream(p, 0, ok1);
      i_rst = 1'b1;
      @(posedge clk); #1; i_rst = 1'b0;
      @(negedge clk);
      checks++; if ({o_core_rstn, o_busy, o_byte_ready, o_imem_wr_en, o_done, o_err} !== 6'b0) begin
         failures++; $display("FAIL rstmid_ctl: rstn/busy/rdy/wr/done/err=%b want 000000", {o_core_rstn, o_busy, o_byte_ready, o_imem_wr_en, o_done, o_err}); end
      checks++; if ({o_imem_addr, o_imem_wr_data, o_checksum} !== '0) begin
         failures++; $display("FAIL rstmid_dat: addr=%h data=%h sum=%h want 0", o_imem_addr, o_imem_wr_data, o_checksum); end
      @(posedge clk); #1;
      idle(3);
      checks++; if (!ok1 || wr_q.size() != 1 || wr_q[0].data !== exp_word(b, 0)) begin
         failures++; $display("FAIL rstmid_wr: got %0d writes want 1 (word 0 only)", wr_q.size()); end
      rand_bytes(4, b); clear_logs();
      do_start(1); stream(b, 2, ok1); wait_done(50, ok2);
      checks++; if (!(ok1 && ok2) || wr_q.size() != 1 || wr_q[0].addr !== 32'h0 || wr_q[0].data !== exp_word(b, 0)) begin
         failures++; $display("FAIL rstmid_reload: got %0d writes first %h@%h want 1 %h@0", wr_q.size(), (wr_q.size() > 0) ? wr_q[0].data : 32'hx, (wr_q.size() > 0) ? wr_q[0].addr : 32'hx, exp_word(b, 0)); end
   endtask

   task automatic test_busy_start();
      logic [7:0] b[$];
      logic [7:0] p0[$];
      logic [7:0] p1[$];
      bit ok1, ok2, ok3;
      rand_bytes(8, b);
      for (int k = 0; k < 8; k++) if (k < 2) p0.push_back(b[k]); else p1.push_back(b[k]);
      clear_logs();
      do_start(2); stream(p0, 0, ok1);
      do_start(1);
      stream(p1, 2, ok2); wait_done(50, ok3);
      checks++; if (!(ok1 && ok2 && ok3) || wr_q.size() != 2) begin
         failures++; $display("FAIL busy_ignored: got %0d writes want 2", wr_q.size()); end
      checks++; if (o_checksum !== exp_sum(b, 2) || o_core_rstn !== 1'b1) begin
         failures++; $display("FAIL busy_sum: got %h rstn=%b want %h 1", o_checksum, o_core_rstn, exp_sum(b, 2)); end
      rand_bytes(4, b); clear_logs();
      do_start(1);
      @(negedge clk);
      checks++; if (o_core_rstn !== 1'b0 || o_busy !== 1'b1) begin
         failures++; $display("FAIL restart_rstn: rstn=%b busy=%b want 0 1", o_core_rstn, o_busy); end
      @(posedge clk); #1;
      stream(b, 0, ok1); wait_done(50, ok2);
      checks++; if (!(ok1 && ok2) || wr_q.size() != 1 || wr_q[0].addr !== 32'h0 || wr_q[0].data !== exp_word(b, 0)) begin
         failures++; $display("FAIL restart_wr: got %0d writes want 1 %h@0", wr_q.size(), exp_word(b, 0)); end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_stall();
      test_zero_and_err();
      test_reset_mid();
      test_busy_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
